// File: rtl/change_dispenser_if.sv
// Bundle of handshake, hopper, sensor and status signals shared between the
// change dispenser and whatever drives it (controller or testbench).
interface change_dispenser_if;
    logic       change_valid;
    logic [4:0] change_amount;
    logic       change_ready;
    logic [2:0] hopper_empty;
    logic       coin_sensed;
    logic       fault_clr;
    logic       eject_10;
    logic       eject_5;
    logic       eject_1;
    logic       busy;
    logic       done;
    logic       fault;
    logic [4:0] remaining;
    logic [4:0] coins_dispensed;

    // Controller side: offers amounts and reports hopper/sensor conditions.
    modport master (
        output change_valid, change_amount, hopper_empty, coin_sensed, fault_clr,
        input  change_ready, eject_10, eject_5, eject_1, busy, done, fault,
               remaining, coins_dispensed
    );

    // Dispenser side: consumes amounts and drives hoppers and status.
    modport slave (
        input  change_valid, change_amount, hopper_empty, coin_sensed, fault_clr,
        output change_ready, eject_10, eject_5, eject_1, busy, done, fault,
               remaining, coins_dispensed
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: accepts an amount, pays it out greedily one coin at a
// time through three hoppers (10/5/1), confirms each coin with the exit
// sensor and reports completion or fault. All outputs are registered.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_SENSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    // One shared counter times the eject pulse, the sensor timeout and the gap;
    // only one of those phases is ever active at a time.
    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [4:0]  remaining_q, remaining_d;
    logic [4:0]  coins_q, coins_d;
    logic [2:0]  eject_q, eject_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [4:0]  denom;

    // Value of the latched coin; sel is one-hot {10, 5, 1}.
    always_comb begin
        denom = 5'd1;
        if (sel_q[2]) begin
            denom = 5'd10;
        end else if (sel_q[1]) begin
            denom = 5'd5;
        end
    end

    // Next-state and next-output logic; outputs are derived from the next state
    // so that each registered output lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;

        case (state_q)
            S_IDLE: begin
                if (bus.change_valid && ready_q) begin
                    remaining_d = bus.change_amount;
                    coins_d     = 5'd0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = 16'd0;
                if (remaining_q == 5'd0) begin
                    state_d = S_DONE;
                end else if (remaining_q >= 5'd10 && !bus.hopper_empty[2]) begin
                    sel_d   = 3'b100;
                    state_d = S_EJECT;
                end else if (remaining_q >= 5'd5 && !bus.hopper_empty[1]) begin
                    sel_d   = 3'b010;
                    state_d = S_EJECT;
                end else if (!bus.hopper_empty[0]) begin
                    sel_d   = 3'b001;
                    state_d = S_EJECT;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EJECT: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_WAIT_SENSE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_SENSE: begin
                if (bus.coin_sensed) begin
                    remaining_d = remaining_q - denom;
                    coins_d     = coins_q + 5'd1;
                    cnt_d       = 16'd0;
                    state_d     = S_GAP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (bus.fault_clr) begin
                    remaining_d = 5'd0;
                    coins_d     = 5'd0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        eject_d = (state_d == S_EJECT) ? sel_d : 3'b000;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    // State and output registers; reset forces every output to its idle value
    // at once, truncating any eject pulse in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            sel_q       <= 3'b000;
            remaining_q <= 5'd0;
            coins_q     <= 5'd0;
            eject_q     <= 3'b000;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            coins_q     <= coins_d;
            eject_q     <= eject_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.change_ready    = ready_q;
    assign bus.eject_10        = eject_q[2];
    assign bus.eject_5         = eject_q[1];
    assign bus.eject_1         = eject_q[0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.fault           = fault_q;
    assign bus.remaining       = remaining_q;
    assign bus.coins_dispensed = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed scenarios plus randomized
// transactions; expected outcomes come from a greedy arithmetic model and are
// queued for a monitor that checks each completion or fault.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 64;

    typedef struct {
        bit is_fault;
        int rem;
        int cnt;
        int n10;
        int n5;
        int n1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sense_mode = 0;
    int   sense_dly  = 0;

    change_dispenser_if bus();

    change_dispenser #(
        .PULSE_CYCLES  (PULSE),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Greedy payout worked out with plain division on the coin values.
    function automatic exp_t modelTxn(input int amt, input logic [2:0] empty);
        exp_t e;
        int r;
        r     = amt;
        e.n10 = empty[2] ? 0 : r / 10;
        r     = r - 10 * e.n10;
        e.n5  = empty[1] ? 0 : r / 5;
        r     = r - 5 * e.n5;
        e.n1  = empty[0] ? 0 : r;
        r     = r - e.n1;
        e.rem = r;
        e.cnt = e.n10 + e.n5 + e.n1;
        e.is_fault = (r != 0);
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    task automatic startTxn(input int amt, input logic [2:0] empty);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.change_ready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) failNow("wait_ready");
        bus.hopper_empty  = empty;
        bus.change_amount = 5'(amt);
        bus.change_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.change_valid  = 1'b0;
    endtask

    task automatic waitEnd(output bit got_fault);
        bit seen;
        seen      = 0;
        got_fault = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (bus.fault) begin
                seen      = 1;
                got_fault = 1;
                break;
            end
        end
        if (!seen) failNow("wait_end");
    endtask

    task automatic clearFault();
        repeat (2) @(negedge clk);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        checkOutput("clr_ready", int'(bus.change_ready), 1);
        checkOutput("clr_fault", int'(bus.fault), 0);
        checkOutput("clr_remaining", int'(bus.remaining), 0);
        checkOutput("clr_coins", int'(bus.coins_dispensed), 0);
    endtask

    task automatic applyStimulus(input int amt, input logic [2:0] empty);
        bit f;
        exp_q.push_back(modelTxn(amt, empty));
        startTxn(amt, empty);
        waitEnd(f);
        if (f) clearFault();
    endtask

    // Exit-sensor model: answers each finished eject pulse after a delay,
    // or never when the sensor is meant to be dead.
    initial begin
        bit prev;
        bit cur;
        int d;
        prev = 0;
        bus.coin_sensed = 1'b0;
        forever begin
            @(negedge clk);
            cur = bus.eject_10 | bus.eject_5 | bus.eject_1;
            if (prev && !cur && !rst && sense_mode == 0) begin
                d = (sense_dly == 0) ? int'($urandom_range(1, 10)) : sense_dly;
                repeat (d) @(negedge clk);
                bus.coin_sensed = 1'b1;
                @(negedge clk);
                bus.coin_sensed = 1'b0;
                cur = bus.eject_10 | bus.eject_5 | bus.eject_1;
            end
            prev = cur;
        end
    end

    // Monitor: tallies eject pulses, checks pulse shape, and on each done or
    // fault pops the queued expectation and compares the outcome.
    initial begin
        logic [2:0] prev_ej;
        logic [2:0] cur_ej;
        bit   prev_fault;
        int   run;
        int   n10, n5, n1;
        exp_t e;
        prev_ej = 3'b000; prev_fault = 0; run = 0; n10 = 0; n5 = 0; n1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ej = 3'b000; prev_fault = 0; run = 0; n10 = 0; n5 = 0; n1 = 0;
            end else begin
                cur_ej = {bus.eject_10, bus.eject_5, bus.eject_1};
                if (cur_ej[2] && !prev_ej[2]) n10++;
                if (cur_ej[1] && !prev_ej[1]) n5++;
                if (cur_ej[0] && !prev_ej[0]) n1++;
                if (cur_ej != 3'b000 && prev_ej == 3'b000)
                    checkOutput("eject_onehot", $countones(cur_ej), 1);
                if (cur_ej != 3'b000) begin
                    run++;
                end else if (run != 0) begin
                    checkOutput("pulse_width", run, PULSE);
                    run = 0;
                end
                prev_ej = cur_ej;
                if (bus.done || (bus.fault && !prev_fault)) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected_end");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("end_kind_fault", int'(bus.fault), int'(e.is_fault));
                        checkOutput("end_remaining", int'(bus.remaining), e.rem);
                        checkOutput("end_coins", int'(bus.coins_dispensed), e.cnt);
                        checkOutput("n10", n10, e.n10);
                        checkOutput("n5", n5, e.n5);
                        checkOutput("n1", n1, e.n1);
                    end
                    n10 = 0; n5 = 0; n1 = 0;
                end
                prev_fault = bus.fault;
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        bit f;
        int k;
        exp_t e;
        bus.change_valid  = 1'b0;
        bus.change_amount = 5'd0;
        bus.hopper_empty  = 3'b000;
        bus.fault_clr     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", int'(bus.change_ready), 1);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_fault", int'(bus.fault), 0);
        checkOutput("rst_ejects", int'({bus.eject_10, bus.eject_5, bus.eject_1}), 0);
        checkOutput("rst_remaining", int'(bus.remaining), 0);
        checkOutput("rst_coins", int'(bus.coins_dispensed), 0);

        sense_dly = 3;
        applyStimulus(15, 3'b000);
        applyStimulus(15, 3'b100);
        applyStimulus(7, 3'b001);

        // Zero amount: done in cycle 2, ready in cycle 3, valid while busy ignored.
        exp_q.push_back(modelTxn(0, 3'b000));
        startTxn(0, 3'b000);
        @(negedge clk);
        checkOutput("zero_c1_busy", int'(bus.busy), 1);
        bus.change_amount = 5'd5;
        bus.change_valid  = 1'b1;
        @(negedge clk);
        checkOutput("zero_c2_done", int'(bus.done), 1);
        checkOutput("zero_c2_ejects", int'({bus.eject_10, bus.eject_5, bus.eject_1}), 0);
        bus.change_valid  = 1'b0;
        @(negedge clk);
        checkOutput("zero_c3_ready", int'(bus.change_ready), 1);
        checkOutput("zero_c3_done", int'(bus.done), 0);
        checkOutput("zero_c3_remaining", int'(bus.remaining), 0);

        // Dead sensor: fault exactly TMO cycles after WAIT_SENSE is entered.
        sense_mode = 1;
        e = '{is_fault: 1, rem: 10, cnt: 0, n10: 1, n5: 0, n1: 0};
        exp_q.push_back(e);
        startTxn(10, 3'b000);
        k = 0;
        while (!bus.eject_10 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (bus.eject_10 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (!bus.fault && k < 200) begin @(negedge clk); k++; end
        checkOutput("timeout_cycles", k, TMO);
        clearFault();

        // Sense arriving on the last timeout cycle wins over the timeout.
        sense_mode = 0;
        sense_dly  = TMO - 1;
        exp_q.push_back(modelTxn(10, 3'b000));
        startTxn(10, 3'b000);
        waitEnd(f);
        checkOutput("late_sense_no_fault", int'(f), 0);
        if (f) clearFault();

        // Reset during the second cycle of a 10 pulse.
        sense_mode = 1;
        startTxn(20, 3'b000);
        k = 0;
        while (!bus.eject_10 && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_eject10", int'(bus.eject_10), 0);
        checkOutput("rst_mid_ready", int'(bus.change_ready), 1);
        checkOutput("rst_mid_busy", int'(bus.busy), 0);
        checkOutput("rst_mid_remaining", int'(bus.remaining), 0);
        checkOutput("rst_mid_coins", int'(bus.coins_dispensed), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_rel_ready", int'(bus.change_ready), 1);
        checkOutput("rst_rel_busy", int'(bus.busy), 0);

        // Randomized transactions against the greedy model.
        sense_mode = 0;
        sense_dly  = 0;
        for (int i = 0; i < 25; i++) begin
            int amt;
            logic [2:0] empty;
            amt   = int'($urandom_range(0, 31));
            empty = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            applyStimulus(amt, empty);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
